clk_div_sched: RTL and testbench

- Programmable clock-enable scheduler that owns the divided-clock resource of the clock generation subsystem.
- Generates a glitch-free divided clock and a one-cycle tick strobe at a runtime-selected ratio.
- Accepts ratio changes over a valid/ready handshake and applies them only at period boundaries.
- Sequences start/stop of the divided clock and counts completed output periods.

---
 rtl/clk_div_sched_if.sv | 25 ++
 rtl/clk_div_sched.sv | 137 +++++++++++++
 tb/tb_clk_div_sched.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_sched_if.sv
// Ratio-request handshake between a requester and the divided-clock scheduler.
// A request transfers on a rising edge where cfg_valid && cfg_ready; cfg_valid
// must be held until then, and cfg_div must stay stable while cfg_valid is high.
interface clk_div_sched_if #(
    parameter int WIDTH = 8
);
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable clock-enable scheduler: divided clock plus tick strobe, with
// ratio changes deferred to period boundaries and stop/start sequencing.
module clk_div_sched #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run_en,
    clk_div_sched_if.slave   cfg,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] active_div,
    output logic [WIDTH-1:0] period_count,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             ready;
    logic             accept;
    logic             boundary;
    logic [WIDTH-1:0] req_div;
    logic [WIDTH:0]   half_d;

    // Ready depends only on the state register, so no input reaches an output.
    assign ready    = (state_q != ST_PEND);
    assign accept   = cfg.cfg_valid && ready;
    assign req_div  = (cfg.cfg_div < TWO) ? TWO : cfg.cfg_div;
    assign boundary = (state_q != ST_IDLE) && (cnt_q == (active_q - ONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        pend_d   = pend_q;
        count_d  = count_q;
        err_d    = accept && (cfg.cfg_div < TWO);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    active_d = req_div;
                end
                if (run_en) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (boundary) begin
                    // A request landing on the boundary edge takes effect right away.
                    if (accept) begin
                        active_d = req_div;
                    end
                    cnt_d   = '0;
                    count_d = count_q + ONE;
                    state_d = run_en ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (accept) begin
                        pend_d  = req_div;
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (boundary) begin
                    active_d = pend_q;
                    cnt_d    = '0;
                    count_d  = count_q + ONE;
                    state_d  = run_en ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Flop-driven outputs are computed from next-state so they align with cnt.
        half_d    = ({1'b0, active_d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        clk_out_d = (state_d != ST_IDLE) && ({1'b0, cnt_d} < half_d);
        tick_d    = (state_d != ST_IDLE) && (cnt_d == (active_d - ONE));
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            active_q  <= WIDTH'(DEFAULT_DIV);
            pend_q    <= '0;
            count_q   <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            count_q   <= count_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
        end
    end

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = err_q;
    assign clk_out       = clk_out_q;
    assign tick          = tick_q;
    assign active_div    = active_q;
    assign period_count  = count_q;
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Randomized and directed bench for clk_div_sched against a period-position model.
module tb_clk_div_sched;

    localparam int WIDTH = 8;
    localparam int DEF   = 2;

    logic             clk_in;
    logic             rst_n;
    logic             run_en;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] period_count;
    logic             busy;
    logic [1:0]       dbg_state;

    clk_div_sched_if #(.WIDTH(WIDTH)) cfg_if ();

    clk_div_sched #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .run_en       (run_en),
        .cfg          (cfg_if.slave),
        .clk_out      (clk_out),
        .tick         (tick),
        .active_div   (active_div),
        .period_count (period_count),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Reference model: "is the divided clock running", ratio in force,
    // position inside the current period and an optional waiting ratio.
    bit m_run;
    int m_pos;
    int m_n;
    bit m_pend;
    int m_pend_n;
    int m_count;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_n = DEF; m_pend = 0; m_pend_n = 0; m_count = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit acc;
        int req;
        acc   = cfg_if.cfg_valid && !m_pend;
        req   = (int'(cfg_if.cfg_div) < 2) ? 2 : int'(cfg_if.cfg_div);
        m_err = acc && (int'(cfg_if.cfg_div) < 2);
        if (!m_run) begin
            if (acc) m_n = req;
            if (run_en) begin
                m_run = 1;
                m_pos = 0;
            end
        end else if (m_pos == m_n - 1) begin
            m_count = (m_count + 1) % 256;
            if (m_pend) m_n = m_pend_n;
            else if (acc) m_n = req;
            m_pend = 0;
            m_pos  = 0;
            m_run  = run_en;
        end else begin
            m_pos++;
            if (acc) begin
                m_pend   = 1;
                m_pend_n = req;
            end
        end
    endtask

    task automatic check_all();
        check("clk_out", 32'(clk_out), 32'(m_run && (m_pos < (m_n + 1) / 2)));
        check("tick", 32'(tick), 32'(m_run && (m_pos == m_n - 1)));
        check("active_div", 32'(active_div), 32'(m_n));
        check("period_count", 32'(period_count), 32'(m_count));
        check("busy", 32'(busy), 32'(m_run));
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!m_pend));
        check("cfg_err", 32'(cfg_if.cfg_err), 32'(m_err));
    endtask

    // driver tasks: inputs are changed only at the falling edge
    task automatic step();
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle();
        int budget;
        budget = 600;
        while (m_run && budget > 0) begin
            step();
            budget--;
        end
        if (m_run) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic request(input logic [WIDTH-1:0] d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = d;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic start_at(input logic [WIDTH-1:0] d);
        run_en = 1'b0;
        wait_idle();
        request(d);
        run_en = 1'b1;
        step();
    endtask

    initial begin
        rst_n            = 1'b0;
        run_en           = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        model_reset();
        repeat (3) @(negedge clk_in);
        check_all();
        check("reset_active", 32'(active_div), 32'd2);
        rst_n = 1'b1;
        step();

        // default ratio: three periods in six cycles after the start edge
        run_en = 1'b1;
        step();
        steps(6);
        check("n2_count", 32'(period_count), 32'd3);

        // ratio 5 loaded while idle
        start_at(8'd5);
        check("n5_active", 32'(active_div), 32'd5);
        steps(10);

        // change 8 -> 3 requested at cnt=2
        start_at(8'd8);
        steps(2);
        request(8'd3);
        check("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        steps(5);
        check("pend_done_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check("pend_done_active", 32'(active_div), 32'd3);
        steps(6);

        // clamp of 1 and 0 while idle
        run_en = 1'b0;
        wait_idle();
        request(8'd1);
        check("clamp1_err", 32'(cfg_if.cfg_err), 32'd1);
        check("clamp1_active", 32'(active_div), 32'd2);
        step();
        request(8'd0);
        check("clamp0_err", 32'(cfg_if.cfg_err), 32'd1);
        step();
        check("clamp0_err_clear", 32'(cfg_if.cfg_err), 32'd0);

        // stop at N=4 requested at cnt=1
        start_at(8'd4);
        step();
        run_en = 1'b0;
        steps(2);
        check("stop_tick", 32'(tick), 32'd1);
        step();
        check("stop_idle", 32'(busy), 32'd0);
        check("stop_clk", 32'(clk_out), 32'd0);

        // async reset while a ratio is pending at N=6
        start_at(8'd6);
        steps(1);
        request(8'd9);
        step();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        check("areset_busy", 32'(busy), 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        run_en = 1'b1;
        steps(8);
        check("areset_active", 32'(active_div), 32'd2);

        // period_count wrap at N=2
        steps(520);

        // random traffic: small ratios, occasional large, random run_en
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) run_en = ~run_en;
            if (!cfg_if.cfg_valid || cfg_if.cfg_ready) begin
                cfg_if.cfg_valid = ($urandom_range(0, 15) == 0);
                cfg_if.cfg_div   = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(0, 40))
                                                              : WIDTH'($urandom_range(0, 7));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
